// File: rtl/flash_sample_streamer.sv
// Streams audio samples out of an Avalon-MM flash: fetches one word at a time and
// emits its slices, one per rising edge of the slow sample trigger.
`timescale 1ns/1ps
module flash_sample_streamer #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           SAMPLE_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH   = 23,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR     = 'h7FFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    waitrequest,
  input  logic [DATA_WIDTH-1:0]   readdata,
  input  logic                    readdatavalid,
  input  logic                    samplenow,
  input  logic                    direction,
  input  logic                    pause,
  input  logic                    restart,
  output logic [SAMPLE_WIDTH-1:0] audio_out,
  output logic                    audio_valid,
  output logic                    underrun
);

  localparam int unsigned N        = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned IdxW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StFetch, StWaitData, StReady, StDiscard} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [IdxW-1:0]         idx_q;
  logic                    dir_q;
  logic                    pending_q;
  logic                    samplenow_q;
  logic                    restart_pend_q;
  logic [ADDR_WIDTH-1:0]   restart_addr_q;

  logic                    edge_det;
  logic                    accept;
  logic                    serve;
  logic                    last_slice;
  logic [ADDR_WIDTH-1:0]   restart_target;
  logic [ADDR_WIDTH-1:0]   step_addr;
  logic [SAMPLE_WIDTH-1:0] slice [N];

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign slice[k] = word_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  assign byteenable     = '1;
  assign edge_det       = samplenow & ~samplenow_q & ~pause;
  assign accept         = read & ~waitrequest;
  assign restart_target = direction ? END_ADDR : START_ADDR;
  // A pending edge is held back while paused so audio_out cannot move.
  assign serve          = (state_q == StReady) & ~pause & (pending_q | edge_det);
  assign last_slice     = dir_q ? (idx_q == '0) : (idx_q == LastIdx);

  always_comb begin
    step_addr = address;
    if (dir_q) begin
      step_addr = (address == START_ADDR) ? END_ADDR : address - 1'b1;
    end else begin
      step_addr = (address == END_ADDR) ? START_ADDR : address + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // A request already in flight must have its data swallowed once reset lifts.
      if (state_q == StWaitData || state_q == StDiscard || (state_q == StFetch && accept)) begin
        state_q <= StDiscard;
      end else begin
        state_q <= StFetch;
      end
      read           <= 1'b0;
      address        <= START_ADDR;
      audio_out      <= '0;
      audio_valid    <= 1'b0;
      underrun       <= 1'b0;
      pending_q      <= 1'b0;
      samplenow_q    <= 1'b1;
      restart_pend_q <= 1'b0;
      restart_addr_q <= START_ADDR;
      idx_q          <= '0;
      dir_q          <= 1'b0;
      word_q         <= '0;
    end else begin
      samplenow_q <= samplenow;
      audio_valid <= 1'b0;
      underrun    <= 1'b0;

      if (restart) begin
        pending_q <= edge_det;
        unique case (state_q)
          StFetch: begin
            if (accept) begin
              state_q        <= StDiscard;
              read           <= 1'b0;
              address        <= restart_target;
              restart_pend_q <= 1'b0;
            end else if (read) begin
              // Address must stay put until the flash takes the request.
              restart_pend_q <= 1'b1;
              restart_addr_q <= restart_target;
            end else begin
              address        <= restart_target;
              read           <= 1'b1;
              restart_pend_q <= 1'b0;
            end
          end
          StWaitData: begin
            state_q <= StDiscard;
            address <= restart_target;
          end
          StDiscard: begin
            address <= restart_target;
            if (readdatavalid) begin
              state_q <= StFetch;
              read    <= 1'b1;
            end
          end
          StReady: begin
            address <= restart_target;
            state_q <= StFetch;
            read    <= 1'b1;
          end
        endcase
      end else begin
        if (serve) begin
          pending_q <= pending_q & edge_det;
        end else if (edge_det) begin
          if (pending_q) underrun <= 1'b1;
          else pending_q <= 1'b1;
        end

        unique case (state_q)
          StFetch: begin
            if (accept) begin
              read <= 1'b0;
              if (restart_pend_q) begin
                state_q        <= StDiscard;
                address        <= restart_addr_q;
                restart_pend_q <= 1'b0;
              end else begin
                state_q <= StWaitData;
              end
            end else begin
              read <= 1'b1;
            end
          end
          StWaitData: begin
            if (readdatavalid) begin
              word_q  <= readdata;
              dir_q   <= direction;
              idx_q   <= direction ? LastIdx : '0;
              state_q <= StReady;
            end
          end
          StDiscard: begin
            if (readdatavalid) begin
              state_q <= StFetch;
              read    <= 1'b1;
            end
          end
          StReady: begin
            if (serve) begin
              audio_out   <= slice[idx_q];
              audio_valid <= 1'b1;
              if (last_slice) begin
                address <= step_addr;
                state_q <= StFetch;
                read    <= 1'b1;
              end else begin
                idx_q <= dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Bench for flash_sample_streamer: Avalon flash responder, directed scenarios and
// randomized playback compared against a word/slice stream model.
`timescale 1ns/1ps
module tb_flash_sample_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 16;
  localparam int unsigned AW = 23;
  localparam int unsigned N  = DW / SW;
  localparam logic [AW-1:0] START = 23'h0;
  localparam logic [AW-1:0] END   = 23'h7FFFF;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          read;
  logic [DW/8-1:0] byteenable;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          samplenow;
  logic          direction;
  logic          pause;
  logic          restart;
  logic [SW-1:0] audio_out;
  logic          audio_valid;
  logic          underrun;

  flash_sample_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .samplenow    (samplenow),
    .direction    (direction),
    .pause        (pause),
    .restart      (restart),
    .audio_out    (audio_out),
    .audio_valid  (audio_valid),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash contents: a scrambled function of the address, with a few fixed words.
  logic [31:0] mem_ovr [int];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Stream model: which word and which slice the next sample comes from.
  logic [AW-1:0] model_addr;
  int            model_pos;
  logic          model_dir;

  function automatic logic [SW-1:0] next_sample();
    logic [31:0] w;
    int          sl;
    w  = mem_word(model_addr);
    sl = model_dir ? (int'(N) - 1 - model_pos) : model_pos;
    model_pos++;
    if (model_pos == int'(N)) begin
      model_pos = 0;
      if (model_dir) model_addr = (model_addr == START) ? END : model_addr - 1'b1;
      else           model_addr = (model_addr == END) ? START : model_addr + 1'b1;
    end
    return w[sl*SW +: SW];
  endfunction

  // Responder knobs and observations.
  int            fixed_wr    = -1;
  bit            hold_data   = 1'b0;
  bit            data_ovr_en = 1'b0;
  logic [31:0]   data_ovr    = '0;
  int            rdv_cyc     = 0;
  logic [AW-1:0] acc_q [$];

  initial begin
    bit            in_req   = 1'b0;
    bit            rsp_busy = 1'b0;
    int            wr_left  = 0;
    int            lat_left = 0;
    logic [AW-1:0] rsp_addr = '0;
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    readdata      = '0;
    forever begin
      @(negedge clk);
      readdatavalid = 1'b0;
      if (rsp_busy) begin
        waitrequest = 1'b1;
        if (lat_left > 0) begin
          lat_left--;
        end else if (!hold_data) begin
          readdatavalid = 1'b1;
          readdata      = data_ovr_en ? data_ovr : mem_word(rsp_addr);
          data_ovr_en   = 1'b0;
          rdv_cyc       = cyc;
          rsp_busy      = 1'b0;
        end
      end else if (read === 1'b1) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wr_left  = (fixed_wr >= 0) ? fixed_wr : int'($urandom_range(0, 3));
          fixed_wr = -1;
        end
        if (wr_left > 0) begin
          waitrequest = 1'b1;
          wr_left--;
        end else begin
          waitrequest = 1'b0;
          in_req      = 1'b0;
          rsp_busy    = 1'b1;
          rsp_addr    = address;
          lat_left    = int'($urandom_range(0, 3));
          acc_q.push_back(address);
        end
      end else begin
        waitrequest = 1'b1;
      end
    end
  end

  // Output monitor: every audio_valid must match the next expected sample,
  // and audio_out must hold in every other cycle.
  logic [SW-1:0] exp_q [$];
  int            av_cnt = 0;
  int            av_cyc = 0;
  int            ur_cnt = 0;

  initial begin
    logic [SW-1:0] last_out = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (audio_valid) begin
          av_cnt++;
          av_cyc = cyc;
          if (exp_q.size() == 0) check_eq("spurious audio_valid", 32'(audio_valid), 32'd0);
          else check_eq("audio_out sample", 32'(audio_out), 32'(exp_q.pop_front()));
        end else begin
          check_eq("audio_out hold", 32'(audio_out), 32'(last_out));
        end
        if (underrun) ur_cnt++;
      end
      last_out = audio_out;
    end
  end

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_edge();
    samplenow = 1'b1;
    repeat (2) @(negedge clk);
    samplenow = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_accept(input string tag, input logic [AW-1:0] exp_addr);
    logic [31:0] got;
    for (int i = 0; i < 200 && acc_q.size() == 0; i++) @(negedge clk);
    got = (acc_q.size() != 0) ? 32'(acc_q.pop_front()) : 32'hFFFF_FFFF;
    check_eq(tag, got, 32'(exp_addr));
  endtask

  // Restart with one direction, then present another by the time the word loads.
  task automatic restart_to(input bit d_rst, input bit d_load);
    acc_q.delete();
    direction = d_rst;
    restart   = 1'b1;
    @(negedge clk);
    restart    = 1'b0;
    direction  = d_load;
    model_addr = d_rst ? END : START;
    model_pos  = 0;
    model_dir  = d_load;
  endtask

  task automatic play(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(next_sample());
      pulse_edge();
      wait_drain(tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int hi_ok;
    int av0;
    int ur0;

    mem_ovr[int'(START)] = 32'h1234_ABCD;
    mem_ovr[int'(END)]   = 32'h1234_ABCD;
    reset = 1'b1; samplenow = 1'b0; direction = 1'b0; pause = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset read", 32'(read), 32'd0);
    check_eq("reset address", 32'(address), 32'(START));
    check_eq("reset audio_out", 32'(audio_out), 32'd0);
    check_eq("reset audio_valid", 32'(audio_valid), 32'd0);
    check_eq("reset underrun", 32'(underrun), 32'd0);
    check_eq("byteenable", 32'(byteenable), 32'hF);
    reset = 1'b0;
    @(negedge clk);
    check_eq("prefetch read", 32'(read), 32'd1);
    check_eq("prefetch address", 32'(address), 32'(START));

    // Forward playback of the first word.
    wait_accept("fwd first addr", START);
    exp_q.push_back(16'hABCD); pulse_edge(); wait_drain("fwd slice0");
    exp_q.push_back(16'h1234); pulse_edge(); wait_drain("fwd slice1");
    wait_accept("fwd next addr", START + 1'b1);

    // Reverse playback from the end of the region.
    settle();
    restart_to(1'b1, 1'b1);
    wait_accept("rev first addr", END);
    exp_q.push_back(16'h1234); pulse_edge(); wait_drain("rev slice1");
    exp_q.push_back(16'hABCD); pulse_edge(); wait_drain("rev slice0");
    wait_accept("rev next addr", END - 1'b1);

    // Five stalled cycles: read and address held for six cycles, one acceptance.
    settle();
    fixed_wr = 5;
    restart_to(1'b0, 1'b0);
    hi = 0; hi_ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (read) hi++;
      if (read && address == START) hi_ok++;
      @(negedge clk);
    end
    check_eq("stall read cycles", 32'(hi), 32'd6);
    check_eq("stall addr stable", 32'(hi_ok), 32'd6);
    check_eq("stall accepts", 32'(acc_q.size()), 32'd1);
    wait_accept("stall addr", START);

    // Forward wrap END -> START, then reverse wrap START -> END.
    settle();
    restart_to(1'b1, 1'b0);
    wait_accept("wrap fwd first", END);
    play(N, "wrap fwd");
    wait_accept("wrap fwd next", START);
    settle();
    restart_to(1'b0, 1'b1);
    wait_accept("wrap rev first", START);
    play(N, "wrap rev");
    wait_accept("wrap rev next", END);

    // Two edges while waiting for data: second is an underrun, first is served late.
    settle();
    hold_data = 1'b1;
    restart_to(1'b0, 1'b0);
    wait_accept("underrun addr", START);
    @(negedge clk);
    ur0 = ur_cnt;
    pulse_edge();
    check_eq("underrun after first", 32'(ur_cnt - ur0), 32'd0);
    pulse_edge();
    check_eq("underrun after second", 32'(ur_cnt - ur0), 32'd1);
    exp_q.push_back(16'hABCD);
    hold_data = 1'b0;
    wait_drain("pending served");
    check_eq("pending latency", 32'(av_cyc - rdv_cyc), 32'd2);

    // Restart while waiting: the in-flight word is dropped and START is re-read.
    settle();
    hold_data = 1'b1;
    restart_to(1'b0, 1'b0);
    wait_accept("discard first addr", START);
    repeat (2) @(negedge clk);
    data_ovr = 32'hDEAD_BEEF; data_ovr_en = 1'b1;
    av0 = av_cnt;
    restart_to(1'b0, 1'b0);
    hold_data = 1'b0;
    wait_accept("discard fresh addr", START);
    settle();
    check_eq("discard no valid", 32'(av_cnt - av0), 32'd0);
    play(1, "after discard");

    // Randomized playback with random stalls, latencies, gaps and paused edges.
    for (int ph = 0; ph < 6; ph++) begin
      bit d;
      settle();
      d = 1'($urandom_range(0, 1));
      restart_to(d, d);
      ur0 = ur_cnt;
      for (int e = 0; e < 24; e++) begin
        if ($urandom_range(0, 5) == 0) begin
          pause = 1'b1;
          pulse_edge();
          pause = 1'b0;
          repeat (3) @(negedge clk);
          check_eq("paused edge ignored", 32'(exp_q.size()), 32'd0);
        end else begin
          play(1, "random stream");
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
      check_eq("random no underrun", 32'(ur_cnt - ur0), 32'd0);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
